// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit hold/shift/load/rotate/clear register (Clk, Reset, En, S, SIR, SIL, I -> Q, Zero)
module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       S,
  input  logic             SIR,
  input  logic             SIL,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Zero
);
  logic [WIDTH-1:0] d;
  always_comb begin
    d = S == 3'b001 ? {SIR, Q[WIDTH-1:1]} :
        S == 3'b010 ? {Q[WIDTH-2:0], SIL} :
        S == 3'b011 ? I :
        S == 3'b100 ? {Q[0], Q[WIDTH-1:1]} :
        S == 3'b101 ? {Q[WIDTH-2:0], Q[WIDTH-1]} :
        S == 3'b110 ? RESET_VALUE : Q;
  end
  always_ff @(posedge Clk) Q <= Reset ? RESET_VALUE : En ? d : Q;
  assign Zero = ~|Q;
endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       r4 = 1'b0, en4 = 1'b0, sir4 = 1'b0, sil4 = 1'b0;
  logic [2:0] s4 = 3'd0;
  logic [3:0] i4 = 4'd0, q4;
  logic       z4;
  logic       r8 = 1'b0, en8 = 1'b0, sir8 = 1'b0, sil8 = 1'b0;
  logic [2:0] s8 = 3'd0;
  logic [7:0] i8 = 8'd0, q8;
  logic       z8;

  universal_shift_reg #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(r4), .En(en4), .S(s4), .SIR(sir4), .SIL(sil4), .I(i4), .Q(q4), .Zero(z4));
  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .Clk(Clk), .Reset(r8), .En(en8), .S(s8), .SIR(sir8), .SIL(sil8), .I(i8), .Q(q8), .Zero(z8));

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic       rst, en;
    logic [2:0] s;
    logic       sir, sil;
    logic [3:0] i, q;
    logic       z;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic rst, logic en, logic [2:0] s, logic sir, logic sil,
                              logic [3:0] i, logic [3:0] q, logic z);
    vec_t t;
    t.rst = rst; t.en = en; t.s = s; t.sir = sir; t.sil = sil; t.i = i; t.q = q; t.z = z;
    return t;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour as arithmetic on an unsigned value modulo 2**w.
  function automatic longint unsigned model(int w, longint unsigned q, longint unsigned rv,
      logic rst, logic en, logic [2:0] s, logic sir, logic sil, longint unsigned i);
    longint unsigned m, h;
    m = 64'd1 << w;
    h = m / 2;
    if (rst) return rv;
    if (!en) return q;
    case (s)
      3'd1: return q / 2 + (sir ? h : 0);
      3'd2: return (q * 2 + (sil ? 1 : 0)) % m;
      3'd3: return i % m;
      3'd4: return q / 2 + (q % 2) * h;
      3'd5: return (q * 2) % m + q / h;
      3'd6: return rv;
      default: return q;
    endcase
  endfunction

  initial begin
    longint unsigned m4, m8;
    // 8-bit instance with non-zero reset value
    r8 = 1'b1; en8 = 1'b0;
    @(posedge Clk); #1;
    chk("w8_reset_q", q8, 64'hA5); chk("w8_reset_zero", z8, 0);
    r8 = 1'b0; en8 = 1'b1; s8 = 3'b011; i8 = 8'h00;
    @(posedge Clk); #1;
    chk("w8_load0_q", q8, 0); chk("w8_load0_zero", z8, 1);
    s8 = 3'b110;
    @(posedge Clk); #1;
    chk("w8_clear_q", q8, 64'hA5);
    s8 = 3'b111; sir8 = 1'b1; sil8 = 1'b1; i8 = 8'hFF;
    @(posedge Clk); #1;
    chk("w8_rsvd_hold", q8, 64'hA5);
    en8 = 1'b0;

    // 4-bit directed vectors
    v.push_back(mk(1, 0, 3'b000, 0, 0, 4'h0, 4'h0, 1));
    v.push_back(mk(1, 1, 3'b011, 0, 0, 4'hF, 4'h0, 1));
    v.push_back(mk(0, 1, 3'b011, 1, 1, 4'hB, 4'hB, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 1, 4'h0, 4'h5, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 1, 4'hF, 4'h2, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 1, 4'h0, 4'h1, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 1, 4'h0, 4'h0, 1));
    v.push_back(mk(0, 1, 3'b011, 0, 0, 4'hB, 4'hB, 0));
    v.push_back(mk(0, 1, 3'b010, 0, 1, 4'h0, 4'h7, 0));
    v.push_back(mk(0, 1, 3'b010, 0, 1, 4'h0, 4'hF, 0));
    v.push_back(mk(0, 1, 3'b100, 0, 0, 4'h0, 4'hF, 0));
    v.push_back(mk(0, 1, 3'b011, 0, 0, 4'h8, 4'h8, 0));
    v.push_back(mk(0, 1, 3'b101, 0, 0, 4'h3, 4'h1, 0));
    v.push_back(mk(0, 1, 3'b100, 0, 0, 4'h3, 4'h8, 0));
    v.push_back(mk(0, 1, 3'b011, 0, 0, 4'h6, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b001, 1, 0, 4'h9, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b010, 0, 1, 4'h3, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b011, 1, 1, 4'hF, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b100, 0, 0, 4'h0, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b101, 1, 0, 4'hA, 4'h6, 0));
    v.push_back(mk(0, 0, 3'b110, 0, 1, 4'h5, 4'h6, 0));
    v.push_back(mk(0, 1, 3'b111, 1, 1, 4'hF, 4'h6, 0));
    v.push_back(mk(0, 1, 3'b110, 1, 1, 4'hF, 4'h0, 1));
    v.push_back(mk(0, 1, 3'b011, 0, 0, 4'h9, 4'h9, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 0, 4'h0, 4'h4, 0));
    v.push_back(mk(0, 1, 3'b001, 0, 0, 4'h0, 4'h2, 0));
    v.push_back(mk(1, 1, 3'b001, 1, 0, 4'h0, 4'h0, 1));
    v.push_back(mk(0, 1, 3'b010, 0, 1, 4'h0, 4'h1, 0));
    foreach (v[k]) begin
      r4 = v[k].rst; en4 = v[k].en; s4 = v[k].s; sir4 = v[k].sir; sil4 = v[k].sil; i4 = v[k].i;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_q", k), q4, v[k].q);
      chk($sformatf("vec%0d_zero", k), z4, v[k].z);
    end

    // Reset raised between edges must not act until the next edge
    r4 = 1'b0; en4 = 1'b1; s4 = 3'b011; i4 = 4'hC;
    @(posedge Clk); #1;
    chk("midcycle_pre", q4, 4'hC);
    r4 = 1'b1; s4 = 3'b000;
    #3;
    chk("midcycle_hold", q4, 4'hC);
    @(posedge Clk); #1;
    chk("midcycle_reset", q4, 0);
    r4 = 1'b0;

    // Randomized run against the arithmetic model, both widths
    m4 = 0; m8 = 64'hA5;
    for (int n = 0; n < 400; n++) begin
      r4 = ($urandom_range(0, 19) == 0); en4 = ($urandom_range(0, 3) != 0);
      s4 = 3'($urandom); sir4 = 1'($urandom); sil4 = 1'($urandom); i4 = 4'($urandom);
      r8 = ($urandom_range(0, 19) == 0); en8 = ($urandom_range(0, 3) != 0);
      s8 = 3'($urandom); sir8 = 1'($urandom); sil8 = 1'($urandom); i8 = 8'($urandom);
      m4 = model(4, m4, 0, r4, en4, s4, sir4, sil4, i4);
      m8 = model(8, m8, 64'hA5, r8, en8, s8, sir8, sil8, i8);
      @(posedge Clk); #1;
      chk($sformatf("rnd%0d_q4", n), q4, m4);
      chk($sformatf("rnd%0d_z4", n), z4, m4 == 0);
      chk($sformatf("rnd%0d_q8", n), q8, m8);
      chk($sformatf("rnd%0d_z8", n), z8, m8 == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VALUE, default 0: WIDTH-bit value loaded into Q on reset and by the CLEAR mode.
REQ-003 Port Clk  input  1: single clock; all state updates on posedge Clk.
REQ-004 Port Reset  input  1: synchronous, active-high reset; sampled on posedge Clk only.
REQ-005 Port En  input  1: operation enable; when 0, Q holds regardless of S.
REQ-006 Port S  input  3: mode select, encoding per REQ-012.
REQ-007 Port SIR  input  1: serial input shifted into Q[WIDTH-1] during shift right.
REQ-008 Port SIL  input  1: serial input shifted into Q[0] during shift left.
REQ-009 Port I  input  WIDTH: parallel load data.
REQ-010 Port Q  output  WIDTH: registered register contents.
REQ-011 Port Zero  output  1: combinational, 1 iff Q == 0.

Function
REQ-012 The block SHALL decode S as: 000 hold; 001 shift right; 010 shift left; 011 parallel load; 100 rotate right; 101 rotate left; 110 clear; 111 hold (reserved).
REQ-013 Hold SHALL leave Q unchanged.
REQ-014 Shift right SHALL set Q <= {SIR, Q[WIDTH-1:1]}; Q[0] is discarded.
REQ-015 Shift left SHALL set Q <= {Q[WIDTH-2:0], SIL}; Q[WIDTH-1] is discarded.
REQ-016 Parallel load SHALL set Q <= I.
REQ-017 Rotate right SHALL set Q <= {Q[0], Q[WIDTH-1:1]}; SIR ignored.
REQ-018 Rotate left SHALL set Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; SIL ignored.
REQ-019 Clear SHALL set Q <= RESET_VALUE.
REQ-020 Every operation SHALL take effect at the posedge Clk on which En=1 and S are sampled; latency exactly one cycle, one operation per cycle.
REQ-021 Inputs not used by the selected mode (SIR, SIL, I) SHALL have no effect on Q.
REQ-022 When En=0, Q SHALL hold for any S, SIR, SIL, I.
REQ-023 Zero SHALL track Q combinationally with no cycle delay and no glitch dependence on inputs other than Q.
REQ-024 No X SHALL propagate into Q from unused inputs; Q after reset SHALL be fully defined.

Reset
REQ-025 On posedge Clk with Reset=1, Q SHALL become RESET_VALUE irrespective of En, S and data inputs.
REQ-026 Reset SHALL take priority over every mode, including a simultaneous parallel load or shift.
REQ-027 Assertion of Reset between clock edges SHALL not change Q until the next posedge Clk.
REQ-028 Reset asserted mid-sequence (e.g. during a multi-cycle shift series) SHALL abort it; the first cycle after Reset deasserts SHALL operate from RESET_VALUE.
REQ-029 After reset with RESET_VALUE=0, Zero SHALL read 1.

Verification
REQ-030 WIDTH=4: Reset=1 one edge -> Q=0000, Zero=1; Reset=1 with En=1, S=011, I=1111 -> Q=0000.
REQ-031 WIDTH=4: load I=1011 (S=011), then S=001 with SIR=0 for 4 edges -> Q=0101, 0010, 0001, 0000; Zero=1 only after 4th edge.
REQ-032 WIDTH=4: load 1011, S=010 SIL=1 two edges -> Q=0111, 1111; then S=100 one edge -> Q=1111; load 1000, S=101 one edge -> 0001.
REQ-033 WIDTH=4: load 0110, En=0 with S cycling 001..110 and random SIR/SIL/I for 6 edges -> Q stays 0110.
REQ-034 WIDTH=8, RESET_VALUE=8'hA5: reset -> Q=A5, Zero=0; load 00, S=110 one edge -> Q=A5; S=111 -> Q holds A5.
REQ-035 WIDTH=4: load 1001, shift right 2 edges, assert Reset on 3rd edge with S=001 -> Q=0000; next edge S=010 SIL=1 -> Q=0001.
